// File: rtl/counter_ctrl_if.sv
// Command and status bundle between a host/sequencer and counter_ctrl.
// Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready;
// the host holds cmd_op/cmd_mode/cmd_data/cfg_div stable while cmd_valid is high.
interface counter_ctrl_if #(
  parameter int WIDTH = 3,
  parameter int DIV_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_mode;
  logic [WIDTH-1:0] cmd_data;
  logic [DIV_W-1:0] cfg_div;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc_pulse;
  logic             done;
  logic             cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_mode, cmd_data, cfg_div,
    input  cmd_ready, q, busy, tc_pulse, done, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mode, cmd_data, cfg_div,
    output cmd_ready, q, busy, tc_pulse, done, cmd_err
  );
endinterface

// File: rtl/counter_ctrl.sv
// Command-driven up-counter with prescaler, terminal value and free-run,
// one-shot and periodic modes. All outputs come straight from flops.
module counter_ctrl #(
  parameter int WIDTH = 3,
  parameter int DIV_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  counter_ctrl_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
  typedef enum logic [1:0] {M_FREE = 2'b00, M_ONESHOT = 2'b01, M_PERIODIC = 2'b10} mode_e;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;
  logic             tick;
  logic             run_tick;

  assign accept = bus.cmd_valid && ready_q;
  assign tick   = (state_q == RUN) && (presc_q == div_q);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    term_d   = term_q;
    div_d    = div_q;
    presc_d  = presc_q;
    ready_d  = 1'b1;
    tc_d     = 1'b0;
    err_d    = 1'b0;
    run_tick = 1'b0;

    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // A command other than START-in-RUN swallows a coincident tick.
    if (accept) begin
      case (bus.cmd_op)
        OP_START: begin
          if (state_q == RUN) begin
            run_tick = tick;
          end else begin
            if (state_q == DONE) cnt_d = '0;
            state_d = RUN;
            div_d   = bus.cfg_div;
            presc_d = '0;
          end
        end
        OP_STOP: begin
          if (state_q == RUN) begin
            state_d = IDLE;
            presc_d = '0;
          end
        end
        OP_LOAD: begin
          if (state_q == RUN) begin
            err_d = 1'b1;
          end else begin
            term_d  = bus.cmd_data;
            cnt_d   = '0;
            state_d = IDLE;
            if (bus.cmd_mode == 2'b11) begin
              mode_d = M_FREE;
              err_d  = 1'b1;
            end else begin
              mode_d = mode_e'(bus.cmd_mode);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          presc_d = '0;
        end
      endcase
    end else begin
      run_tick = tick;
    end

    if (run_tick) begin
      case (mode_q)
        M_PERIODIC: begin
          if (cnt_q == term_q) begin
            cnt_d = '0;
            tc_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        M_ONESHOT: begin
          if (cnt_q == term_q) begin
            tc_d    = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d = cnt_q + 1'b1;
          tc_d  = (cnt_q == '1);
        end
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= M_FREE;
      cnt_q   <= '0;
      term_q  <= '1;
      div_q   <= '0;
      presc_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      term_q  <= term_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.q         = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.tc_pulse  = tc_q;
  assign bus.done      = done_q;
  assign bus.cmd_err   = err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: inputs change and outputs are sampled on the
// falling edge, so each sample reflects the state after the preceding rising edge.
module tb_counter_ctrl;
  localparam int WIDTH = 3;
  localparam int DIV_W = 4;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         total;
  int         bad;

  counter_ctrl_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

  counter_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller sits on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic [1:0] op, input logic [1:0] mode,
                       input logic [WIDTH-1:0] data, input logic [DIV_W-1:0] div);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mode  = mode;
    bus.cmd_data  = data;
    bus.cfg_div   = div;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00; bus.cmd_mode = 2'b00; bus.cmd_data = '0; bus.cfg_div = '0;
    repeat (2) @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", bus.cmd_ready); end
    total++; if (bus.q !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tc_pulse !== 1'b0 || bus.cmd_err !== 1'b0)
      begin bad++; $display("FAIL reset_outs q=%0d busy=%0b done=%0b tc=%0b err=%0b want all 0", bus.q, bus.busy, bus.done, bus.tc_pulse, bus.cmd_err); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release got=%0b want=1", bus.cmd_ready); end
    total++; if (state_dbg !== 2'b00) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (bus.q !== 3'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL idle_hold cyc=%0d q=%0d busy=%0b want q=0 busy=0", i, bus.q, bus.busy); end
    end
  endtask

  task automatic test_free();
    logic [WIDTH-1:0] eq;
    issue(OP_START, 2'b00, 3'd0, 4'd0);
    total++; if (bus.busy !== 1'b1 || bus.q !== 3'd0) begin bad++; $display("FAIL free_start busy=%0b q=%0d want busy=1 q=0", bus.busy, bus.q); end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      eq = 3'(k % 8);
      total++; if (bus.q !== eq) begin bad++; $display("FAIL free_q k=%0d got=%0d want=%0d", k, bus.q, eq); end
      total++; if (bus.tc_pulse !== (k % 8 == 0)) begin bad++; $display("FAIL free_tc k=%0d got=%0b want=%0b", k, bus.tc_pulse, (k % 8 == 0)); end
    end
    issue(OP_CLEAR, 2'b00, 3'd0, 4'd0);
    total++; if (bus.q !== 3'd0 || bus.busy !== 1'b0) begin bad++; $display("FAIL free_clear q=%0d busy=%0b want q=0 busy=0", bus.q, bus.busy); end
  endtask

  task automatic test_periodic();
    logic [WIDTH-1:0] eq;
    issue(OP_LOAD, 2'b10, 3'd4, 4'd0);
    total++; if (bus.q !== 3'd0 || bus.cmd_err !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL per_load q=%0d err=%0b busy=%0b want 0 0 0", bus.q, bus.cmd_err, bus.busy); end
    issue(OP_START, 2'b00, 3'd0, 4'd2);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      eq = 3'((k / 3) % 5);
      total++; if (bus.q !== eq) begin bad++; $display("FAIL per_q k=%0d got=%0d want=%0d", k, bus.q, eq); end
      total++; if (bus.tc_pulse !== (k % 15 == 0)) begin bad++; $display("FAIL per_tc k=%0d got=%0b want=%0b", k, bus.tc_pulse, (k % 15 == 0)); end
    end
    issue(OP_CLEAR, 2'b00, 3'd0, 4'd0);
  endtask

  task automatic test_oneshot();
    issue(OP_LOAD, 2'b01, 3'd5, 4'd0);
    issue(OP_START, 2'b00, 3'd0, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++; if (bus.q !== 3'(k) || bus.busy !== 1'b1 || bus.tc_pulse !== 1'b0) begin bad++; $display("FAIL os_run k=%0d q=%0d busy=%0b tc=%0b want q=%0d busy=1 tc=0", k, bus.q, bus.busy, bus.tc_pulse, k); end
    end
    @(negedge clk);
    total++; if (bus.q !== 3'd5 || bus.tc_pulse !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0)
      begin bad++; $display("FAIL os_term q=%0d tc=%0b done=%0b busy=%0b want 5 1 1 0", bus.q, bus.tc_pulse, bus.done, bus.busy); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (bus.q !== 3'd5 || bus.tc_pulse !== 1'b0 || bus.done !== 1'b1 || state_dbg !== 2'b10)
        begin bad++; $display("FAIL os_hold q=%0d tc=%0b done=%0b st=%0d want 5 0 1 2", bus.q, bus.tc_pulse, bus.done, state_dbg); end
    end
    issue(OP_START, 2'b00, 3'd0, 4'd0);
    total++; if (bus.q !== 3'd0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL os_restart q=%0d done=%0b busy=%0b want 0 0 1", bus.q, bus.done, bus.busy); end
    @(negedge clk);
    total++; if (bus.q !== 3'd1) begin bad++; $display("FAIL os_restart_inc got=%0d want=1", bus.q); end
    issue(OP_CLEAR, 2'b00, 3'd0, 4'd0);
  endtask

  task automatic test_stop_resume();
    issue(OP_LOAD, 2'b00, 3'd7, 4'd0);
    issue(OP_START, 2'b00, 3'd0, 4'd0);
    repeat (3) @(negedge clk);
    issue(OP_STOP, 2'b00, 3'd0, 4'd0);
    total++; if (bus.q !== 3'd3 || bus.busy !== 1'b0 || bus.tc_pulse !== 1'b0) begin bad++; $display("FAIL stop q=%0d busy=%0b tc=%0b want 3 0 0", bus.q, bus.busy, bus.tc_pulse); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.q !== 3'd3) begin bad++; $display("FAIL stop_hold cyc=%0d got=%0d want=3", i, bus.q); end
    end
    issue(OP_START, 2'b00, 3'd0, 4'd0);
    total++; if (bus.q !== 3'd3 || bus.busy !== 1'b1) begin bad++; $display("FAIL resume q=%0d busy=%0b want 3 1", bus.q, bus.busy); end
    @(negedge clk);
    total++; if (bus.q !== 3'd4) begin bad++; $display("FAIL resume_4 got=%0d want=4", bus.q); end
    @(negedge clk);
    total++; if (bus.q !== 3'd5) begin bad++; $display("FAIL resume_5 got=%0d want=5", bus.q); end
    issue(OP_CLEAR, 2'b00, 3'd0, 4'd0);
  endtask

  task automatic test_collisions();
    issue(OP_LOAD, 2'b00, 3'd7, 4'd0);
    issue(OP_START, 2'b00, 3'd0, 4'd0);
    repeat (2) @(negedge clk);
    issue(OP_LOAD, 2'b10, 3'd3, 4'd0);
    total++; if (bus.cmd_err !== 1'b1 || bus.q !== 3'd2 || bus.busy !== 1'b1 || bus.tc_pulse !== 1'b0)
      begin bad++; $display("FAIL load_in_run err=%0b q=%0d busy=%0b tc=%0b want 1 2 1 0", bus.cmd_err, bus.q, bus.busy, bus.tc_pulse); end
    @(negedge clk);
    total++; if (bus.cmd_err !== 1'b0 || bus.q !== 3'd3) begin bad++; $display("FAIL err_pulse err=%0b q=%0d want 0 3", bus.cmd_err, bus.q); end
    @(negedge clk);
    total++; if (bus.q !== 3'd4) begin bad++; $display("FAIL term_unchanged got=%0d want=4", bus.q); end
    repeat (3) @(negedge clk);
    issue(OP_STOP, 2'b00, 3'd0, 4'd0);
    total++; if (bus.q !== 3'd7 || bus.tc_pulse !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL stop_on_tick q=%0d tc=%0b busy=%0b want 7 0 0", bus.q, bus.tc_pulse, bus.busy); end
    issue(OP_CLEAR, 2'b00, 3'd0, 4'd0);

    issue(OP_LOAD, 2'b11, 3'd2, 4'd0);
    total++; if (bus.cmd_err !== 1'b1 || bus.q !== 3'd0) begin bad++; $display("FAIL load_rsvd err=%0b q=%0d want 1 0", bus.cmd_err, bus.q); end
    issue(OP_START, 2'b00, 3'd0, 4'd0);
    total++; if (bus.cmd_err !== 1'b0) begin bad++; $display("FAIL rsvd_err_clear got=%0b want=0", bus.cmd_err); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      total++; if (bus.q !== 3'(k % 8) || bus.tc_pulse !== (k == 8)) begin bad++; $display("FAIL rsvd_free k=%0d q=%0d tc=%0b want q=%0d tc=%0b", k, bus.q, bus.tc_pulse, k % 8, (k == 8)); end
    end
    repeat (6) @(negedge clk);
    total++; if (bus.q !== 3'd6) begin bad++; $display("FAIL pre_rst got=%0d want=6", bus.q); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.q !== 3'd0 || bus.busy !== 1'b0 || bus.tc_pulse !== 1'b0 || bus.cmd_ready !== 1'b0)
      begin bad++; $display("FAIL mid_rst q=%0d busy=%0b tc=%0b ready=%0b want 0 0 0 0", bus.q, bus.busy, bus.tc_pulse, bus.cmd_ready); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.cmd_ready !== 1'b1 || bus.q !== 3'd0) begin bad++; $display("FAIL post_rst ready=%0b q=%0d want 1 0", bus.cmd_ready, bus.q); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    test_reset();
    test_free();
    test_periodic();
    test_oneshot();
    test_stop_resume();
    test_collisions();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
